// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Instruction fetch stage of the 32-bit MIPS core. Owns the fetch
//            PC, issues word reads to instruction memory over a req/ack
//            handshake, buffers returned instructions together with their PC
//            in a small FIFO and presents them to decode over valid/ready.
//            A redirect from execute flushes the FIFO and restarts fetching
//            at the new target; an in-flight read is allowed to finish but
//            its data is thrown away.
// Ports    :
//   clk            in   clock, all state on rising edge
//   rst_n          in   asynchronous, active-low reset
//   redirect_valid in   one-cycle pulse: taken branch/jump
//   redirect_pc    in   redirect target (bits [1:0] ignored)
//   imem_req       out  read request (registered)
//   imem_addr      out  read address (registered, stable while imem_req)
//   imem_ack       in   read complete, imem_rdata valid this cycle
//   imem_rdata     in   instruction word
//   inst_valid     out  FIFO non-empty
//   inst_ready     in   decode accepts head entry
//   inst_data      out  head instruction
//   inst_pc        out  PC of head instruction
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                FIFO_DEPTH = 2,
  parameter logic [ADDR_W-1:0] RESET_PC   = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output logic [ADDR_W-1:0] inst_pc
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w = $clog2(FIFO_DEPTH + 1);

  localparam logic [c_cnt_w-1:0] c_depth      = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);
  localparam logic [c_ptr_w-1:0] c_ptr_one    = c_ptr_w'(1);
  localparam logic [ADDR_W-1:0]  c_word_bytes = ADDR_W'(4);
  localparam logic [ADDR_W-1:0]  c_align_mask = {{(ADDR_W-2){1'b1}}, 2'b00};

  // IDLE: no request outstanding
  // REQ : request outstanding, its data will be pushed
  // DROP: request outstanding, its data belongs to a redirected-away path
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_e;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   fetch_pc_q,  fetch_pc_d;
  logic                imem_req_q,  imem_req_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;

  logic [c_cnt_w-1:0]  count_q,     count_d;
  logic [c_ptr_w-1:0]  rd_ptr_q,    rd_ptr_d;
  logic [c_ptr_w-1:0]  wr_ptr_q,    wr_ptr_d;
  logic [DATA_W-1:0]   data_mem_q [FIFO_DEPTH];
  logic [DATA_W-1:0]   data_mem_d [FIFO_DEPTH];
  logic [ADDR_W-1:0]   pc_mem_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0]   pc_mem_d   [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // Handshake decode
  // --------------------------------------------------------------------------
  logic              w_complete;
  logic              w_push;
  logic              w_pop;
  logic              w_credit;
  logic [ADDR_W-1:0] w_redirect_target;

  assign w_complete        = imem_req_q && imem_ack;
  assign w_redirect_target = redirect_pc & c_align_mask;

  // A redirect cancels both sides of the FIFO in the same cycle: the
  // returning word is from the old path and the head is about to be flushed.
  assign w_push = (state_q == REQ) && w_complete && !redirect_valid;
  assign w_pop  = (count_q != '0) && inst_ready && !redirect_valid;

  // Credit is judged on the occupancy after this cycle's push/pop; since only
  // one request is ever outstanding, this guarantees room for its data.
  assign w_credit = (count_d < c_depth);

  // --------------------------------------------------------------------------
  // FIFO next-state
  // --------------------------------------------------------------------------
  always_comb begin
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    data_mem_d = data_mem_q;
    pc_mem_d   = pc_mem_q;

    if (redirect_valid) begin
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (w_push) begin
        data_mem_d[wr_ptr_q] = imem_rdata;
        pc_mem_d[wr_ptr_q]   = imem_addr_q;
        wr_ptr_d             = wr_ptr_q + c_ptr_one;
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + c_ptr_one;
      end
      case ({w_push, w_pop})
        2'b10:   count_d = count_q + c_cnt_one;
        2'b01:   count_d = count_q - c_cnt_one;
        default: count_d = count_q;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Fetch FSM next-state
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    imem_req_d  = imem_req_q;
    imem_addr_d = imem_addr_q;

    case (state_q)
      IDLE: begin
        if (redirect_valid) begin
          fetch_pc_d = w_redirect_target;
        end else if (w_credit) begin
          imem_req_d  = 1'b1;
          imem_addr_d = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + c_word_bytes;
          state_d     = REQ;
        end
      end

      REQ: begin
        if (redirect_valid) begin
          fetch_pc_d = w_redirect_target;
          if (w_complete) begin
            imem_req_d = 1'b0;
            state_d    = IDLE;
          end else begin
            // Request cannot be withdrawn; keep req/addr and discard later.
            state_d = DROP;
          end
        end else if (w_complete) begin
          if (w_credit) begin
            imem_addr_d = fetch_pc_q;
            fetch_pc_d  = fetch_pc_q + c_word_bytes;
          end else begin
            imem_req_d = 1'b0;
            state_d    = IDLE;
          end
        end
      end

      DROP: begin
        if (redirect_valid) begin
          fetch_pc_d = w_redirect_target;
        end
        // The stale request finishing frees the bus; fetching resumes from
        // fetch_pc (already holding the newest target) via IDLE.
        if (w_complete) begin
          imem_req_d = 1'b0;
          state_d    = IDLE;
        end
      end

      default: begin
        imem_req_d = 1'b0;
        state_d    = IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      imem_req_q  <= 1'b0;
      imem_addr_q <= RESET_PC;
      count_q     <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      imem_req_q  <= imem_req_d;
      imem_addr_q <= imem_addr_d;
      count_q     <= count_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
    end
  end

  // Storage is reset so that inst_data/inst_pc read as zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        pc_mem_q[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= data_mem_d[i];
        pc_mem_q[i]   <= pc_mem_d[i];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_req   = imem_req_q;
  assign imem_addr  = imem_addr_q;
  assign inst_valid = (count_q != '0);
  assign inst_data  = data_mem_q[rd_ptr_q];
  assign inst_pc    = pc_mem_q[rd_ptr_q];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed self-checking bench for instr_fetch_unit. A small
//            memory model acks each request after ack_lat cycles and returns
//            addr ^ 32'hA5A5A5A5 as the instruction word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_lat = 1;
  int wait_cnt = 0;

  localparam logic [31:0] c_xor = 32'hA5A5_A5A5;

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc)
  );

  // Memory model: ack in the ack_lat-th cycle the request is held high.
  always @(posedge clk) begin
    if (!imem_req || imem_ack) wait_cnt <= 0;
    else                       wait_cnt <= wait_cnt + 1;
  end
  assign imem_ack   = imem_req && (wait_cnt >= ack_lat - 1);
  assign imem_rdata = imem_addr ^ c_xor;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Hold reset across two edges, release just after an edge.
  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    inst_ready     = 1'b1;
    rst_n          = 1'b0;
    #2;

    // ---------------- Reset and streaming ----------------
    ack_lat = 1;
    rst_n = 1'b0;
    tick();
    tick();
    check_value("rst_req",   32'(imem_req),   32'd0);
    check_value("rst_valid", 32'(inst_valid), 32'd0);
    check_value("rst_addr",  imem_addr,       32'h0);
    check_value("rst_pc",    inst_pc,         32'h0);
    check_value("rst_data",  inst_data,       32'h0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_value("stream_addr", imem_addr, 32'(4 * k));
      check_value("stream_req",  32'(imem_req), 32'd1);
      if (k > 0) begin
        check_value("stream_valid", 32'(inst_valid), 32'd1);
        check_value("stream_pc",    inst_pc,   32'(4 * (k - 1)));
        check_value("stream_data",  inst_data, 32'(4 * (k - 1)) ^ c_xor);
      end
    end

    // ---------------- Backpressure ----------------
    inst_ready = 1'b0;
    do_reset();
    tick();                                   // launch 0
    tick();                                   // 0 returns, launch 4
    check_value("bp_addr4", imem_addr, 32'h4);
    check_value("bp_req4",  32'(imem_req), 32'd1);
    tick();                                   // 4 returns, FIFO full
    check_value("bp_req_drop", 32'(imem_req),   32'd0);
    check_value("bp_valid",    32'(inst_valid), 32'd1);
    check_value("bp_pc0",      inst_pc,         32'h0);
    tick();
    tick();
    check_value("bp_req_hold",  32'(imem_req), 32'd0);
    check_value("bp_pc_hold",   inst_pc,       32'h0);
    check_value("bp_data_hold", inst_data,     32'hA5A5_A5A5);
    inst_ready = 1'b1;
    tick();                                   // pop 0, relaunch at 8
    check_value("bp_pc4",   inst_pc,        32'h4);
    check_value("bp_data4", inst_data,      32'hA5A5_A5A1);
    check_value("bp_rereq", 32'(imem_req),  32'd1);
    check_value("bp_addr8", imem_addr,      32'h8);
    tick();
    check_value("bp_pc8",   inst_pc,        32'h8);
    check_value("bp_data8", inst_data,      32'hA5A5_A5AD);

    // ---------------- Redirect with pending read ----------------
    ack_lat = 3;
    do_reset();
    tick();                                   // launch 0
    check_value("rd_addr0", imem_addr, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    tick();                                   // REQ -> DROP
    redirect_valid = 1'b0;
    check_value("rd_hold_addr1", imem_addr,       32'h0);
    check_value("rd_hold_req1",  32'(imem_req),   32'd1);
    check_value("rd_valid1",     32'(inst_valid), 32'd0);
    tick();
    check_value("rd_hold_addr2", imem_addr,     32'h0);
    check_value("rd_hold_req2",  32'(imem_req), 32'd1);
    tick();                                   // stale ack, discarded
    check_value("rd_req_idle",   32'(imem_req),   32'd0);
    check_value("rd_valid_drop", 32'(inst_valid), 32'd0);
    tick();
    check_value("rd_new_addr", imem_addr,     32'h100);
    check_value("rd_new_req",  32'(imem_req), 32'd1);
    tick();
    tick();
    check_value("rd_valid_wait", 32'(inst_valid), 32'd0);
    tick();
    check_value("rd_valid_new", 32'(inst_valid), 32'd1);
    check_value("rd_pc_new",    inst_pc,         32'h100);
    check_value("rd_data_new",  inst_data,       32'hA5A5_A4A5);

    // ---------------- Simultaneous redirect/ack/pop ----------------
    ack_lat = 1;
    do_reset();
    tick();
    tick();
    tick();
    check_value("sim_pre_pc", inst_pc, 32'h4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    tick();
    redirect_valid = 1'b0;
    check_value("sim_valid", 32'(inst_valid), 32'd0);
    check_value("sim_req",   32'(imem_req),   32'd0);
    tick();
    check_value("sim_addr",   imem_addr,       32'h200);
    check_value("sim_valid2", 32'(inst_valid), 32'd0);
    tick();
    check_value("sim_valid3", 32'(inst_valid), 32'd1);
    check_value("sim_pc",     inst_pc,         32'h200);

    // ---------------- Address wrap ----------------
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    check_value("wrap_flush", 32'(inst_valid), 32'd0);
    tick();
    check_value("wrap_addr_top", imem_addr, 32'hFFFF_FFFC);
    tick();
    check_value("wrap_addr_zero", imem_addr, 32'h0);
    check_value("wrap_pc_top",    inst_pc,   32'hFFFF_FFFC);
    check_value("wrap_data_top",  inst_data, 32'h5A5A_5A59);
    tick();
    check_value("wrap_pc_zero",   inst_pc,   32'h0);
    check_value("wrap_data_zero", inst_data, 32'hA5A5_A5A5);
    check_value("wrap_addr_four", imem_addr, 32'h4);

    // ---------------- Reset mid-transaction ----------------
    ack_lat    = 3;
    inst_ready = 1'b0;
    do_reset();
    tick();
    tick();
    tick();
    tick();                                   // 0 buffered, 4 pending
    check_value("mid_pre_req",   32'(imem_req),   32'd1);
    check_value("mid_pre_valid", 32'(inst_valid), 32'd1);
    check_value("mid_pre_addr",  imem_addr,       32'h4);
    #3;
    rst_n = 1'b0;
    #1;
    check_value("mid_req",   32'(imem_req),   32'd0);
    check_value("mid_valid", 32'(inst_valid), 32'd0);
    check_value("mid_addr",  imem_addr,       32'h0);
    check_value("mid_data",  inst_data,       32'h0);
    tick();
    rst_n      = 1'b1;
    inst_ready = 1'b1;
    tick();
    check_value("mid_restart_addr", imem_addr,     32'h0);
    check_value("mid_restart_req",  32'(imem_req), 32'd1);
    tick();
    tick();
    tick();
    check_value("mid_restart_valid", 32'(inst_valid), 32'd1);
    check_value("mid_restart_pc",    inst_pc,         32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
